riscv_seq_divider: RTL and testbench
====================================

// Module: riscv_seq_divider
// PURPOSE
//  Iterative radix-2 restoring divider for the M-extension execute stage (DIV/DIVU/REM/REMU plus W forms).
//  Generalises the signed/unsigned operand-extension helpers to a parametrised XLEN/WLEN datapath that runs as a multi-cycle FSM.
//  Accepts one operation at a time and holds its result until the next accept.
//  Supports pipeline kill.
// PARAMETERS
//  XLEN   64  full operand/result width; even, >=8
//  WLEN   32  word-op width (W forms); WLEN<XLEN
// PORTS
//  clk       in   1     single clock, rising edge
//  rst       in   1     synchronous, active-high reset
//  i_start   in   1     request; sampled only when o_ready=1
//  i_kill    in   1     flush; abort any in-flight op
//  i_op      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  i_word    in   1     1 = W form: use rs[WLEN-1:0]
//  i_rs1     in   XLEN  dividend
//  i_rs2     in   XLEN  divisor
//  o_ready   out  1     1 only in IDLE
//  o_done    out  1     one-cycle pulse: o_result valid
//  o_result  out  XLEN  quotient or remainder; held until next accept
// BEHAVIOUR
//  Reset: state IDLE, o_ready=1, o_done=0, o_result=0, iteration counter 0.
//  FSM states and transitions:
//   IDLE -> CALC on i_start & o_ready & !i_kill. Latch |rs1|, |rs2|, result signs, op, word.
//   IDLE -> DONE on accept when a special case applies. Special cases bypass CALC.
//   CALC: one quotient bit per cycle. Runs N cycles; N=XLEN, or WLEN if i_word. Then -> FIX.
//   FIX: negate quotient if signs differ (signed ops). Negate remainder if dividend negative. Then -> DONE.
//   DONE: o_done=1 for exactly this cycle; o_result updated on the edge entering DONE. Then -> IDLE.
//  Latency from accept edge to o_done high:
//   normal op: N+2 cycles
//   special case: 1 cycle
//  Operand extension:
//   signed ops: {msb,x}
//   unsigned ops: {0,x}
//   W forms: extend bit WLEN-1 of each operand.
//  W result: the WLEN-bit result is sign-extended to XLEN for all four ops, DIVUW/REMUW included.
//  Special cases (evaluated at the effective width):
//   divisor==0: quotient = all ones; remainder = dividend.
//   signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
//  Handshake:
//   i_start ignored while o_ready=0.
//   No queueing; the requester retries in IDLE.
//   i_kill has priority over everything: any state -> IDLE next edge.
//   On kill: o_done suppressed; o_result keeps its previous value.
//   i_kill & i_start in the same IDLE cycle: no accept.
//  rst mid-operation: returns to the reset state; no o_done is produced.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   At accept, if |dividend| < |divisor| (unsigned magnitudes, no special case): go directly to DONE.
//   Result: q=0, r=original dividend (W-form sign-extended). Latency 1.
//  DIV_EARLY_OUT_EN undefined:
//   Such operands take the full N+2 path with identical results.
// STRUCTURE
//  Shared package riscv_div_pkg:
//   div_op_e enum (DIV/DIVU/REM/REMU)
//   div_state_e enum (IDLE/CALC/FIX/DONE)
//   extension functions as_signed/as_unsigned/as_signedw/as_unsignedw, generalised to XLEN/WLEN.
//  Sub-module riscv_div_operand_prep (combinational):
//   width select, sign/zero extension, absolute values, special-case and early-out flags.
//  Top holds the FSM, counter, remainder/quotient shift registers and the FIX negation.
// TESTING
//  1. DIV rs1=-20, rs2=3 -> o_done 66 cycles after accept; result=-6 (0xFFFF_FFFF_FFFF_FFFA).
//  2. REMUW rs1=0x0000_0000_FFFF_FFFF, rs2=0x10 -> done after 34; result=0xF.
//     DIVUW same operands -> 0x0000_0000_0FFF_FFFF.
//  3. DIV rs2=0 -> done 1 cycle later, result=0xFFFF_FFFF_FFFF_FFFF.
//     REM rs1=7, rs2=0 -> 7.
//  4. DIVW rs1=0x8000_0000, rs2=-1 -> result 0xFFFF_FFFF_8000_0000.
//     REMW same operands -> 0.
//  5. Start DIVU, assert i_kill at CALC cycle 10 -> IDLE next edge, no o_done, o_result unchanged.
//     i_start while busy is ignored.
//  6. DIVU rs1=5, rs2=9 -> result 0.
//     Latency 1 with DIV_EARLY_OUT_EN, 66 without; reset applied mid-CALC -> o_ready=1, o_result=0.

Source files
------------

// File: rtl/riscv_div_pkg.sv
// Shared types and operand-extension helpers for the sequential divider.
// Extension helpers work on a MAXW-bit container so any XLEN<MAXW fits.
package riscv_div_pkg;

   localparam int MAXW = 256;

   typedef logic [MAXW:0] ext_t;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   localparam logic [1:0] L_IDLE = 2'd0;
   localparam logic [1:0] L_CALC = 2'd1;
   localparam logic [1:0] L_FIX  = 2'd2;
   localparam logic [1:0] L_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = L_IDLE,
      CALC = L_CALC,
      FIX  = L_FIX,
      DONE = L_DONE
   } div_state_e;

   function automatic ext_t as_unsigned(
      input logic [MAXW-1:0] x,
      input int              w
   );
      ext_t m;
      m = {(MAXW+1){1'b1}} << w;
      return {1'b0, x} & ~m;
   endfunction

   function automatic ext_t as_signed(
      input logic [MAXW-1:0] x,
      input int              w
   );
      ext_t m;
      logic sb;
      m  = {(MAXW+1){1'b1}} << w;
      sb = |({1'b0, x} & (ext_t'(1) << (w - 1)));
      return sb ? ({1'b0, x} | m) : ({1'b0, x} & ~m);
   endfunction

   function automatic ext_t as_unsignedw(
      input logic [MAXW-1:0] x,
      input int              wlen
   );
      return as_unsigned(x, wlen);
   endfunction

   function automatic ext_t as_signedw(
      input logic [MAXW-1:0] x,
      input int              wlen
   );
      return as_signed(x, wlen);
   endfunction

endpackage

// File: rtl/riscv_div_operand_prep.sv
// Operand conditioning: width select, extension, magnitudes, bypass result.
// DIV_EARLY_OUT_EN adds the |dividend|<|divisor| bypass.
module riscv_div_operand_prep
   import riscv_div_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int WLEN = 32
) (
   input  div_op_e         i_op,
   input  logic            i_word,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic [XLEN-1:0] o_abs_a,
   output logic [XLEN-1:0] o_abs_b,
   output logic            o_neg_q,
   output logic            o_neg_r,
   output logic            o_fast,
   output logic [XLEN-1:0] o_fast_res
);

   localparam logic [XLEN-1:0] TOP_X =
      {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] TOP_W =
      {{(XLEN-WLEN){1'b0}}, 1'b1, {(WLEN-1){1'b0}}};

   logic            w_signed;
   logic            w_rem;
   ext_t            w_ea;
   ext_t            w_eb;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [XLEN-1:0] w_dvd;
   logic [XLEN-1:0] w_raw;
   logic            w_div0;
   logic            w_ovf;
   logic            w_early;
   logic            w_unused_ext;

   assign w_signed = (i_op == DIV) || (i_op == REM);
   assign w_rem    = (i_op == REM) || (i_op == REMU);

   // Extend both operands to XLEN+1 bits at the effective width
   always_comb begin
      w_ea = '0;
      w_eb = '0;
      unique case (1'b1)
         (i_word && w_signed): begin
            w_ea = as_signedw(MAXW'(i_rs1), WLEN);
            w_eb = as_signedw(MAXW'(i_rs2), WLEN);
         end
         (i_word && !w_signed): begin
            w_ea = as_unsignedw(MAXW'(i_rs1), WLEN);
            w_eb = as_unsignedw(MAXW'(i_rs2), WLEN);
         end
         (!i_word && w_signed): begin
            w_ea = as_signed(MAXW'(i_rs1), XLEN);
            w_eb = as_signed(MAXW'(i_rs2), XLEN);
         end
         default: begin
            w_ea = as_unsigned(MAXW'(i_rs1), XLEN);
            w_eb = as_unsigned(MAXW'(i_rs2), XLEN);
         end
      endcase
   end

   assign w_neg_a = w_ea[XLEN];
   assign w_neg_b = w_eb[XLEN];
   assign w_dvd   = w_ea[XLEN-1:0];

   assign o_abs_a = w_neg_a ? ~w_dvd + 1'b1 : w_dvd;
   assign o_abs_b = w_neg_b ? ~w_eb[XLEN-1:0] + 1'b1
                            : w_eb[XLEN-1:0];
   assign o_neg_q = w_neg_a ^ w_neg_b;
   assign o_neg_r = w_neg_a;

   assign w_div0 = (o_abs_b == '0);
   assign w_ovf  = w_signed && w_neg_a && (&w_eb[XLEN:0])
                && (o_abs_a == (i_word ? TOP_W : TOP_X));

`ifdef DIV_EARLY_OUT_EN
   assign w_early = (o_abs_a < o_abs_b);
`else
   assign w_early = 1'b0;
`endif

   assign o_fast = w_div0 | w_ovf | w_early;

   // Result for operations that skip the iterative datapath
   always_comb begin
      w_raw = '0;
      unique case (1'b1)
         w_div0:  w_raw = w_rem ? w_dvd : '1;
         w_ovf:   w_raw = w_rem ? '0 : w_dvd;
         default: w_raw = w_rem ? w_dvd : '0;
      endcase
   end

   assign o_fast_res = i_word
      ? {{(XLEN-WLEN){w_raw[WLEN-1]}}, w_raw[WLEN-1:0]}
      : w_raw;

   assign w_unused_ext =
      ^{w_ea[MAXW:XLEN+1], w_eb[MAXW:XLEN+1]};

endmodule

// File: rtl/riscv_seq_divider.sv
// Radix-2 restoring divider FSM for DIV/DIVU/REM/REMU and W forms.
// Build option DIV_EARLY_OUT_EN: 1-cycle bypass when |rs1| < |rs2|.
module riscv_seq_divider
   import riscv_div_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int WLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic [1:0]      i_op,
   input  logic            i_word,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_ready,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN) + 1;

   logic [1:0]      r_state;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_div;
   logic [XLEN-1:0] r_result;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_is_rem;
   logic            r_word;

   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_neg_q;
   logic            w_neg_r;
   logic            w_fast;
   logic [XLEN-1:0] w_fast_res;
   logic [XLEN-1:0] w_quo_init;
   logic [XLEN:0]   w_t;
   logic            w_ge;
   logic [XLEN-1:0] w_diff;
   logic            w_last;
   logic [XLEN-1:0] w_sel;
   logic [XLEN-1:0] w_fix_res;

   riscv_div_operand_prep #(
      .XLEN (XLEN),
      .WLEN (WLEN)
   ) u_prep (
      .i_op       (div_op_e'(i_op)),
      .i_word     (i_word),
      .i_rs1      (i_rs1),
      .i_rs2      (i_rs2),
      .o_abs_a    (w_abs_a),
      .o_abs_b    (w_abs_b),
      .o_neg_q    (w_neg_q),
      .o_neg_r    (w_neg_r),
      .o_fast     (w_fast),
      .o_fast_res (w_fast_res)
   );

   assign w_quo_init = i_word ? (w_abs_a << (XLEN - WLEN))
                              : w_abs_a;

   assign w_t    = {r_rem, r_quo[XLEN-1]};
   assign w_ge   = (w_t >= {1'b0, r_div});
   assign w_diff = w_t[XLEN-1:0] - r_div;
   assign w_last = (r_cnt == (r_word ? CW'(WLEN - 1)
                                     : CW'(XLEN - 1)));

   // Select and sign-correct the final quotient or remainder
   always_comb begin
      w_sel = '0;
      if (r_is_rem)
         w_sel = r_neg_r ? ~r_rem + 1'b1 : r_rem;
      else
         w_sel = r_neg_q ? ~r_quo + 1'b1 : r_quo;
   end

   assign w_fix_res = r_word
      ? {{(XLEN-WLEN){w_sel[WLEN-1]}}, w_sel[WLEN-1:0]}
      : w_sel;

   // Control FSM and datapath registers; kill wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= L_IDLE;
         r_cnt    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_result <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_rem <= 1'b0;
         r_word   <= 1'b0;
      end else if (i_kill) begin
         r_state <= L_IDLE;
         r_cnt   <= '0;
      end else begin
         unique case (1'b1)
            (r_state == L_IDLE): begin
               if (i_start) begin
                  if (w_fast) begin
                     r_result <= w_fast_res;
                     r_state  <= L_DONE;
                  end else begin
                     r_quo    <= w_quo_init;
                     r_rem    <= '0;
                     r_div    <= w_abs_b;
                     r_cnt    <= '0;
                     r_neg_q  <= w_neg_q;
                     r_neg_r  <= w_neg_r;
                     r_is_rem <= i_op[1];
                     r_word   <= i_word;
                     r_state  <= L_CALC;
                  end
               end
            end
            (r_state == L_CALC): begin
               r_rem <= w_ge ? w_diff : w_t[XLEN-1:0];
               r_quo <= {r_quo[XLEN-2:0], w_ge};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= L_FIX;
               end
            end
            (r_state == L_FIX): begin
               r_result <= w_fix_res;
               r_state  <= L_DONE;
            end
            default: r_state <= L_IDLE;
         endcase
      end
   end

   assign o_ready  = (r_state == L_IDLE);
   assign o_done   = (r_state == L_DONE);
   assign o_result = r_result;

endmodule

// File: tb/tb_riscv_seq_divider.sv
// Randomised bench for riscv_seq_divider against an arithmetic model.
// Expected latency follows DIV_EARLY_OUT_EN when it is defined.
module tb_riscv_seq_divider;

   localparam int XLEN = 64;
   localparam int WLEN = 32;

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            i_start;
   logic            i_kill;
   logic [1:0]      i_op;
   logic            i_word;
   logic [XLEN-1:0] i_rs1;
   logic [XLEN-1:0] i_rs2;
   logic            o_ready;
   logic            o_done;
   logic [XLEN-1:0] o_result;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] last_res = '0;

   riscv_seq_divider #(
      .XLEN (XLEN),
      .WLEN (WLEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_kill   (i_kill),
      .i_op     (i_op),
      .i_word   (i_word),
      .i_rs1    (i_rs1),
      .i_rs2    (i_rs2),
      .o_ready  (o_ready),
      .o_done   (o_done),
      .o_result (o_result)
   );

   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
      end
   endtask

   // RISC-V division semantics computed with plain integer arithmetic
   function automatic logic [63:0] ref_div(
      input  logic [1:0]  op,
      input  logic        w,
      input  logic [63:0] a,
      input  logic [63:0] b,
      output int          lat
   );
      logic        sgn;
      logic [63:0] ea, eb, mn, ma, mb, q, r, res;
      sgn = ~op[0];
      if (!w) begin
         ea = a;
         eb = b;
      end else if (sgn) begin
         ea = {{32{a[31]}}, a[31:0]};
         eb = {{32{b[31]}}, b[31:0]};
      end else begin
         ea = {32'h0, a[31:0]};
         eb = {32'h0, b[31:0]};
      end
      mn  = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      ma  = (sgn && ea[63]) ? -ea : ea;
      mb  = (sgn && eb[63]) ? -eb : eb;
      lat = (w ? WLEN : XLEN) + 2;
      if (eb == 64'd0) begin
         q = '1;
         r = ea;
         lat = 1;
      end else if (sgn && ea == mn && eb == '1) begin
         q = ea;
         r = '0;
         lat = 1;
      end else begin
         if (sgn) begin
            q = $signed(ea) / $signed(eb);
            r = $signed(ea) % $signed(eb);
         end else begin
            q = ea / eb;
            r = ea % eb;
         end
         if (EARLY && ma < mb) lat = 1;
      end
      res = op[1] ? r : q;
      if (w) res = {{32{res[31]}}, res[31:0]};
      return res;
   endfunction

   task automatic run_op(
      input logic [1:0]  op,
      input logic        w,
      input logic [63:0] a,
      input logic [63:0] b,
      input string       tag,
      input bit          poke
   );
      int          lat, elat;
      logic [63:0] exp;
      exp = ref_div(op, w, a, b, elat);
      @(negedge clk);
      i_start = 1'b1;
      i_op    = op;
      i_word  = w;
      i_rs1   = a;
      i_rs2   = b;
      @(negedge clk);
      i_start = 1'b0;
      lat = 1;
      while (!o_done && lat < 200) begin
         if (poke && lat == 3) begin
            i_start = 1'b1;
            i_op    = 2'b00;
            i_rs2   = '0;
         end else begin
            i_start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      i_start = 1'b0;
      check({tag, " lat"}, 64'(lat), 64'(elat));
      check({tag, " res"}, o_result, exp);
      last_res = exp;
      @(negedge clk);
      check({tag, " pulse"}, 64'({o_done, o_ready}), 64'd1);
   endtask

   function automatic logic [63:0] rand_operand(input logic w);
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0:       v = {$urandom, $urandom};
         1:       v = 64'($urandom_range(0, 20));
         2:       v = '0;
         3:       v = '1;
         4:       v = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
         default: v = -(64'($urandom_range(1, 20)));
      endcase
      if (w && $urandom_range(0, 1) == 1) v[63:32] = $urandom;
      return v;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst     = 1'b1;
      i_start = 1'b0;
      i_kill  = 1'b0;
      i_op    = 2'b00;
      i_word  = 1'b0;
      i_rs1   = '0;
      i_rs2   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst ready", 64'(o_ready), 64'd1);
      check("rst done", 64'(o_done), 64'd0);
      check("rst result", o_result, 64'd0);

      run_op(2'b00, 1'b0, -64'd20, 64'd3, "div_neg", 1'b0);
      check("div_neg lit", last_res, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(2'b11, 1'b1, 64'hFFFF_FFFF, 64'h10, "remuw", 1'b0);
      run_op(2'b01, 1'b1, 64'hFFFF_FFFF, 64'h10, "divuw", 1'b0);
      run_op(2'b00, 1'b0, 64'h1234, 64'd0, "div_by0", 1'b0);
      run_op(2'b10, 1'b0, 64'd7, 64'd0, "rem_by0", 1'b0);
      run_op(2'b00, 1'b1, 64'h8000_0000, '1, "divw_ovf", 1'b0);
      run_op(2'b10, 1'b1, 64'h8000_0000, '1, "remw_ovf", 1'b0);
      run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1,
             "div_ovf", 1'b0);
      run_op(2'b01, 1'b0, 64'd5, 64'd9, "divu_small", 1'b0);
      run_op(2'b01, 1'b0, 64'd1000, 64'd7, "busy_poke", 1'b1);

      // kill mid-CALC
      @(negedge clk);
      i_start = 1'b1;
      i_op    = 2'b01;
      i_word  = 1'b0;
      i_rs1   = 64'd12345;
      i_rs2   = 64'd7;
      @(negedge clk);
      i_start = 1'b0;
      cnt = 1;
      while (cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      i_kill = 1'b1;
      @(negedge clk);
      i_kill = 1'b0;
      check("kill ready", 64'(o_ready), 64'd1);
      check("kill done", 64'(o_done), 64'd0);
      check("kill result", o_result, last_res);
      cnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (o_done) cnt++;
      end
      check("kill no_done", 64'(cnt), 64'd0);

      // kill and start together in IDLE
      @(negedge clk);
      i_start = 1'b1;
      i_kill  = 1'b1;
      i_op    = 2'b00;
      i_rs1   = 64'd9;
      i_rs2   = 64'd0;
      @(negedge clk);
      i_start = 1'b0;
      i_kill  = 1'b0;
      check("kill_start done", 64'(o_done), 64'd0);
      check("kill_start ready", 64'(o_ready), 64'd1);
      check("kill_start result", o_result, last_res);

      for (int k = 0; k < 150; k++) begin
         logic        w;
         logic [1:0]  op;
         w  = 1'($urandom_range(0, 1));
         op = 2'($urandom_range(0, 3));
         run_op(op, w, rand_operand(w), rand_operand(w), "rnd",
                $urandom_range(0, 3) == 0);
      end

      // reset mid-CALC
      @(negedge clk);
      i_start = 1'b1;
      i_op    = 2'b00;
      i_word  = 1'b0;
      i_rs1   = 64'h7FFF_0000_1234;
      i_rs2   = 64'd3;
      @(negedge clk);
      i_start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst ready", 64'(o_ready), 64'd1);
      check("midrst done", 64'(o_done), 64'd0);
      check("midrst result", o_result, 64'd0);
      cnt = 0;
      repeat (70) begin
         @(negedge clk);
         if (o_done) cnt++;
      end
      check("midrst no_done", 64'(cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
